// File: rtl/neg_serial_unit_pkg.sv
// rtl/neg_serial_unit_pkg.sv - shared mode codes, FSM encodings and helpers for the negate/abs unit
// Contents:
//   MODE_PASS/NEG/ABS/NABS  2-bit operation codes carried on in_mode
//   S_IDLE/S_RUN/S_DONE     FSM state encodings
//   inv_for_mode()          whether the operand must be inverted (+1 via carry-in) for a mode
package neg_serial_unit_pkg;

   localparam logic [1:0] MODE_PASS = 2'b00;
   localparam logic [1:0] MODE_NEG  = 2'b01;
   localparam logic [1:0] MODE_ABS  = 2'b10;
   localparam logic [1:0] MODE_NABS = 2'b11;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   // ABS negates only negative operands; NABS negates only non-negative ones.
   function automatic logic inv_for_mode(input logic [1:0] mode, input logic sign);
      case (mode)
         MODE_PASS: inv_for_mode = 1'b0;
         MODE_NEG:  inv_for_mode = 1'b1;
         MODE_ABS:  inv_for_mode = sign;
         default:   inv_for_mode = ~sign;
      endcase
   endfunction

endpackage

// File: rtl/neg_serial_unit_if.sv
// rtl/neg_serial_unit_if.sv - operand/result handshake bundle for the negate/abs unit
// Signals:
//   in_valid/in_ready, in_a[WIDTH], in_mode[2]        operand channel
//   out_valid/out_ready, out_y[WIDTH], out_ovf, out_zero  result channel
// Modports: master (producer of operands, consumer of results), slave (the unit)
interface neg_serial_unit_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [1:0]       in_mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_ovf;
   logic             out_zero;

   modport master (
      output in_valid, in_a, in_mode, out_ready,
      input  in_ready, out_valid, out_y, out_ovf, out_zero
   );

   modport slave (
      input  in_valid, in_a, in_mode, out_ready,
      output in_ready, out_valid, out_y, out_ovf, out_zero
   );
endinterface

// File: rtl/neg_serial_unit_slice.sv
// rtl/neg_serial_unit_slice.sv - one digit of the conditional invert-and-increment carry chain
// Ports:
//   a_d[DIGIT]  operand digit      inv  invert operand digit
//   cin         carry in           y_d[DIGIT], cout  result digit and carry out
module neg_digit_slice #(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic             inv,
   input  logic             cin,
   output logic [DIGIT-1:0] y_d,
   output logic             cout
);
   assign {cout, y_d} = {1'b0, a_d ^ {DIGIT{inv}}} + {{DIGIT{1'b0}}, cin};
endmodule

// File: rtl/neg_serial_unit.sv
// rtl/neg_serial_unit.sv - digit-serial two's-complement pass/negate/abs/nabs unit
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; discards any in-flight operation
//   bus   neg_serial_unit_if.slave: operand in (valid/ready), result out (valid/ready, y, ovf, zero)
// One operation takes WIDTH/DIGIT cycles, LSB digit first; the result is held until taken.
module neg_serial_unit
   import neg_serial_unit_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DIGIT = 8
) (
   input logic                clk,
   input logic                rst,
   neg_serial_unit_if.slave   bus
);
   localparam int NCYC = WIDTH / DIGIT;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("neg_serial_unit: DIGIT must be >= 1 and divide WIDTH");
   end

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] y_reg;
   logic             inv;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             valid;
   logic             ovf;
   logic             zero;

   logic [DIGIT-1:0] y_d;
   logic             cout;
   logic [WIDTH-1:0] y_next;
   logic             last;

   neg_digit_slice #(.DIGIT(DIGIT)) u_slice (
      .a_d  (a_sh[DIGIT-1:0]),
      .inv  (inv),
      .cin  (carry),
      .y_d  (y_d),
      .cout (cout)
   );

   // Result digits enter at the top and shift down, so digit 0 lands at the LSB after NCYC steps.
   if (NCYC == 1) begin : g_single
      assign y_next = y_d;
   end else begin : g_multi
      assign y_next = {y_d, y_reg[WIDTH-1:DIGIT]};
   end

   assign last = (cnt == CW'(NCYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         a_sh  <= '0;
         y_reg <= '0;
         inv   <= 1'b0;
         carry <= 1'b0;
         cnt   <= '0;
         valid <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  a_sh  <= bus.in_a;
                  inv   <= inv_for_mode(bus.in_mode, bus.in_a[WIDTH-1]);
                  carry <= inv_for_mode(bus.in_mode, bus.in_a[WIDTH-1]);
                  cnt   <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               a_sh  <= a_sh >> DIGIT;
               y_reg <= y_next;
               carry <= cout;
               if (last) begin
                  state <= S_DONE;
                  valid <= 1'b1;
                  // Inverting yields MIN only when the operand itself was MIN.
                  ovf   <= inv & (y_next == MIN_VAL);
                  zero  <= (y_next == '0);
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  valid <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == S_IDLE) & ~rst;
   assign bus.out_valid = valid;
   assign bus.out_y     = y_reg;
   assign bus.out_ovf   = ovf;
   assign bus.out_zero  = zero;
endmodule

// File: tb/tb_neg_serial_unit.sv
// tb/tb_neg_serial_unit.sv - self-checking bench for neg_serial_unit at DIGIT = 8, 64 and 1
module tb_neg_serial_unit;
   import neg_serial_unit_pkg::*;

   typedef struct {
      logic [63:0] y;
      logic        ovf;
      logic        zero;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [63:0] in_a = '0;
   logic [1:0]  in_mode = 2'b00;
   logic        out_ready = 1'b0;

   logic [2:0]  rdy, vld, ovf, zro;
   logic [63:0] yv [3];

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int DG = (k == 0) ? 8 : (k == 1) ? 64 : 1;
      neg_serial_unit_if #(.WIDTH(64)) bus ();
      assign bus.in_valid  = in_valid;
      assign bus.in_a      = in_a;
      assign bus.in_mode   = in_mode;
      assign bus.out_ready = out_ready;
      assign rdy[k]        = bus.in_ready;
      assign vld[k]        = bus.out_valid;
      assign yv[k]         = bus.out_y;
      assign ovf[k]        = bus.out_ovf;
      assign zro[k]        = bus.out_zero;
      neg_serial_unit #(.WIDTH(64), .DIGIT(DG)) dut (.clk(clk), .rst(rst), .bus(bus));
   end

   function automatic int lat_of(input int k);
      lat_of = (k == 0) ? 8 : (k == 1) ? 1 : 64;
   endfunction

   function automatic exp_t model(input logic [63:0] a, input logic [1:0] m);
      exp_t  e;
      logic  neg_it;
      case (m)
         MODE_PASS: neg_it = 1'b0;
         MODE_NEG:  neg_it = 1'b1;
         MODE_ABS:  neg_it = $signed(a) < 0;
         default:   neg_it = $signed(a) >= 0;
      endcase
      e.y    = neg_it ? (64'd0 - a) : a;
      e.ovf  = neg_it && (a == 64'h8000_0000_0000_0000);
      e.zero = (e.y == 64'd0);
      return e;
   endfunction

   task automatic start_op(input logic [63:0] a, input logic [1:0] m, input exp_t e, input string name);
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_mode  = m;
      exp_q.push_back(e);
      n_cmp++;
      if (rdy !== 3'b111) begin
         n_err++;
         $display("FAIL %s in_ready before accept: got %b want 111", name, rdy);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n_cmp++;
      if (vld !== 3'b000) begin
         n_err++;
         $display("FAIL %s out_valid right after accept: got %b want 000", name, vld);
      end
   endtask

   task automatic wait_done(input string name);
      int lat [3];
      bit seen [3];
      int cyc = 0;
      for (int k = 0; k < 3; k++) begin
         seen[k] = 1'b0;
         lat[k]  = 0;
      end
      while (!(seen[0] && seen[1] && seen[2]) && cyc < 200) begin
         @(posedge clk);
         cyc++;
         #1;
         for (int k = 0; k < 3; k++)
            if (vld[k] && !seen[k]) begin
               seen[k] = 1'b1;
               lat[k]  = cyc;
            end
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (!seen[k] || lat[k] != lat_of(k)) begin
            n_err++;
            $display("FAIL %s latency inst%0d: got %0d (seen=%0b) want %0d", name, k, lat[k], seen[k], lat_of(k));
         end
      end
   endtask

   task automatic check_outputs(input exp_t e, input string name);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (yv[k] !== e.y || ovf[k] !== e.ovf || zro[k] !== e.zero || vld[k] !== 1'b1) begin
            n_err++;
            $display("FAIL %s result inst%0d: got y=%h ovf=%b zero=%b valid=%b want y=%h ovf=%b zero=%b valid=1",
                     name, k, yv[k], ovf[k], zro[k], vld[k], e.y, e.ovf, e.zero);
         end
      end
   endtask

   task automatic release_result(input string name);
      exp_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s scoreboard empty: got 0 entries want 1", name);
         return;
      end
      e = exp_q.pop_front();
      check_outputs(e, name);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_cmp++;
      if (vld !== 3'b000 || rdy !== 3'b111) begin
         n_err++;
         $display("FAIL %s after handshake: got valid=%b ready=%b want valid=000 ready=111", name, vld, rdy);
      end
   endtask

   task automatic run_op(input logic [63:0] a, input logic [1:0] m,
                         input logic [63:0] ey, input logic eo, input logic ez, input string name);
      exp_t e;
      e.y = ey; e.ovf = eo; e.zero = ez;
      start_op(a, m, e, name);
      wait_done(name);
      release_result(name);
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (rdy !== 3'b000 || vld !== 3'b000 || ovf !== 3'b000 || zro !== 3'b000) begin
         n_err++;
         $display("FAIL reset_hold: got ready=%b valid=%b ovf=%b zero=%b want all 000", rdy, vld, ovf, zro);
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (yv[k] !== 64'd0) begin
            n_err++;
            $display("FAIL reset_y inst%0d: got %h want 0", k, yv[k]);
         end
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (rdy !== 3'b111 || vld !== 3'b000) begin
         n_err++;
         $display("FAIL reset_release: got ready=%b valid=%b want ready=111 valid=000", rdy, vld);
      end
   endtask

   task automatic test_neg();
      run_op(64'd3, MODE_NEG, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, "neg_3");
      run_op(64'd0, MODE_NEG, 64'd0, 1'b0, 1'b1, "neg_0");
      run_op(64'h8000_0000_0000_0000, MODE_NEG, 64'h8000_0000_0000_0000, 1'b1, 1'b0, "neg_min");
   endtask

   task automatic test_abs_pass();
      run_op(64'hFFFF_FFFF_FFFF_FFDF, MODE_ABS, 64'h21, 1'b0, 1'b0, "abs_m33");
      run_op(64'h20, MODE_ABS, 64'h20, 1'b0, 1'b0, "abs_32");
      run_op(64'h8000_0000_0000_0000, MODE_ABS, 64'h8000_0000_0000_0000, 1'b1, 1'b0, "abs_min");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, MODE_PASS, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "pass_m1");
   endtask

   task automatic test_nabs();
      run_op(64'd5, MODE_NABS, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, "nabs_5");
      run_op(64'hFFFF_FFFF_FFFF_FFF9, MODE_NABS, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, "nabs_m7");
      run_op(64'd0, MODE_NABS, 64'd0, 1'b0, 1'b1, "nabs_0");
      run_op(64'h8000_0000_0000_0000, MODE_NABS, 64'h8000_0000_0000_0000, 1'b0, 1'b0, "nabs_min");
   endtask

   task automatic test_back_pressure();
      exp_t e;
      e.y = 64'hFFFF_FFFF_FFFF_FF85; e.ovf = 1'b0; e.zero = 1'b0;
      start_op(64'h7B, MODE_NEG, e, "bp");
      wait_done("bp");
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = (c == 2);
         in_a     = 64'h1111;
         in_mode  = MODE_PASS;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         n_cmp++;
         if (rdy !== 3'b000) begin
            n_err++;
            $display("FAIL bp_in_ready cycle %0d: got %b want 000", c, rdy);
         end
         check_outputs(e, "bp_hold");
      end
      release_result("bp");
      run_op(64'h1111, MODE_NEG, 64'hFFFF_FFFF_FFFF_EEEF, 1'b0, 1'b0, "bp_next");
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = 64'h0123_4567_89AB_CDEF;
      in_mode  = MODE_NEG;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (vld !== 3'b000 || rdy !== 3'b000 || ovf !== 3'b000 || zro !== 3'b000) begin
         n_err++;
         $display("FAIL midrst_flags: got valid=%b ready=%b ovf=%b zero=%b want all 000", vld, rdy, ovf, zro);
      end
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (yv[k] !== 64'd0) begin
            n_err++;
            $display("FAIL midrst_y inst%0d: got %h want 0", k, yv[k]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if (rdy !== 3'b111 || vld !== 3'b000) begin
         n_err++;
         $display("FAIL midrst_release: got ready=%b valid=%b want ready=111 valid=000", rdy, vld);
      end
      run_op(64'd1, MODE_NEG, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, "midrst_neg1");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         logic [63:0] a;
         logic [1:0]  m;
         exp_t        e;
         a = {$urandom, $urandom};
         m = 2'($urandom_range(0, 3));
         e = model(a, m);
         run_op(a, m, e.y, e.ovf, e.zero, "random");
      end
   endtask

   initial begin
      test_reset();
      test_neg();
      test_abs_pass();
      test_nabs();
      test_back_pressure();
      test_reset_mid_run();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
